// File: rtl/bulk_xform_pkg.sv
// bulk_xform_pkg: ASCII constants and the byte transform shared by the bulk byte processor
package bulk_xform_pkg;
  localparam logic [7:0] CH_A_UP = 8'h41;
  localparam logic [7:0] CH_Z_UP = 8'h5A;
  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_8 = 8'h38;
  localparam logic [7:0] CH_9 = 8'h39;
  localparam logic [7:0] CASE_OFFSET = 8'h20;
  function automatic logic [7:0] xform_byte(input logic [7:0] b);
    return (b >= CH_A_UP && b <= CH_Z_UP) ? b + CASE_OFFSET :
           (b >= CH_0 && b <= CH_8) ? b + 8'd1 :
           (b == CH_9) ? CH_0 : b;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: ready/valid FIFO (i_data/i_valid/o_ready push, o_data/o_valid/i_ready pop, o_level occupancy)
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [W-1:0]               i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [W-1:0]               o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0] r_level;
  logic w_push;
  logic w_pop;
  assign o_ready = r_level != (AW+1)'(DEPTH);
  assign o_valid = r_level != '0;
  assign o_data = r_mem[r_rd];
  assign o_level = r_level;
  assign w_push = i_valid && o_ready;
  assign w_pop = o_valid && i_ready;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_push);
      r_rd <= r_rd + AW'(w_pop);
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/bulk_xform_app.sv
// bulk_xform_app: transforms CDC OUT bytes into a FIFO feeding the IN stream and stretches transfers onto led_o
module bulk_xform_app
  import bulk_xform_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LED_CYCLES = 2000000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             out_data_i,
  input  logic                   out_valid_i,
  output logic                   out_ready_o,
  output logic [7:0]             in_data_o,
  output logic                   in_valid_o,
  input  logic                   in_ready_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   led_o
);
  logic [31:0] r_led;
  logic w_xfer;
  sync_fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_data  (xform_byte(out_data_i)),
    .i_valid (out_valid_i),
    .o_ready (out_ready_o),
    .o_data  (in_data_o),
    .o_valid (in_valid_o),
    .i_ready (in_ready_i),
    .o_level (level_o)
  );
  assign w_xfer = (out_valid_i && out_ready_o) || (in_valid_o && in_ready_i);
  assign led_o = r_led != '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) r_led <= '0;
    else r_led <= w_xfer ? 32'(LED_CYCLES) : r_led - 32'(led_o);
  end
endmodule

// File: tb/tb_bulk_xform_app.sv
// tb_bulk_xform_app: randomized scoreboard bench for bulk_xform_app against a behavioural model
module tb_bulk_xform_app;
  localparam int DEPTH = 8;
  localparam int LED = 10;
  logic clk_i = 0;
  logic rst_i = 1;
  logic [7:0] out_data_i = 0;
  logic out_valid_i = 0;
  logic out_ready_o;
  logic [7:0] in_data_o;
  logic in_valid_o;
  logic in_ready_i = 0;
  logic [3:0] level_o;
  logic led_o;
  logic [7:0] exp_q[$];
  int m_led = 0;
  bit m_full = 0;
  int n_chk = 0;
  int n_pass = 0;
  int mon_sz;
  bit mon_xfer;
  always #5 clk_i = ~clk_i;
  bulk_xform_app #(.DEPTH(DEPTH), .LED_CYCLES(LED)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .out_data_i  (out_data_i),
    .out_valid_i (out_valid_i),
    .out_ready_o (out_ready_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .level_o     (level_o),
    .led_o       (led_o)
  );
  function automatic logic [7:0] ref_xform(input logic [7:0] b);
    if (b >= 8'd65 && b <= 8'd90) return b + 8'd32;
    if (b >= 8'd48 && b <= 8'd57) return 8'(48 + (int'(b) - 48 + 1) % 10);
    return b;
  endfunction
  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask
  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
      m_led = 0;
      m_full = 0;
    end else begin
      mon_sz = exp_q.size();
      check("level", int'(level_o), mon_sz);
      check("out_ready", int'(out_ready_o), int'(mon_sz < DEPTH));
      check("in_valid", int'(in_valid_o), int'(mon_sz > 0));
      check("led", int'(led_o), int'(m_led != 0));
      mon_xfer = (in_ready_i && mon_sz > 0) || (out_valid_i && mon_sz < DEPTH);
      if (in_ready_i && mon_sz > 0) begin
        check("in_data", int'(in_data_o), int'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      m_full = mon_sz == DEPTH;
      m_led = mon_xfer ? LED : (m_led > 0 ? m_led - 1 : 0);
    end
  end
  task automatic drive(input logic ov, input logic [7:0] od, input logic ir, output bit acc);
    @(posedge clk_i);
    #1;
    rst_i = 0;
    out_valid_i = ov;
    out_data_i = od;
    in_ready_i = ir;
    @(negedge clk_i);
    #1;
    acc = ov && !m_full;
    if (acc) exp_q.push_back(ref_xform(od));
  endtask
  task automatic do_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1;
    out_valid_i = 0;
    in_ready_i = 0;
    @(negedge clk_i);
  endtask
  task automatic idle(input int n, input logic ir);
    bit acc;
    for (int i = 0; i < n; i++) drive(0, 8'($urandom), ir, acc);
  endtask
  task automatic send(input logic [7:0] b, input logic ir);
    bit acc;
    int tries = 0;
    do begin
      drive(1, b, ir, acc);
      tries++;
    end while (!acc && tries < 100);
    if (!acc) check("accept_timeout", 0, 1);
  endtask
  initial begin
    string s;
    bit acc;
    int cyc;
    repeat (3) do_reset();
    for (int b = 1; b <= 7; b++) send(8'(b), 1);
    idle(3, 1);
    s = "ABCDEFGHQRSTUVWX123456789a~";
    for (int i = 0; i < s.len(); i++) send(s[i], 1);
    idle(5, 1);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      int tries = 0;
      do begin
        drive(1, 8'($urandom), cyc >= 12, acc);
        cyc++;
        tries++;
      end while (!acc && tries < 100);
      if (!acc) check("full_timeout", 0, 1);
    end
    idle(12, 1);
    for (int i = 0; i < DEPTH; i++) send(8'($urandom), 0);
    for (int i = 0; i < 5; i++) drive(1, 8'($urandom), 1, acc);
    idle(12, 1);
    for (int i = 0; i < 5; i++) send(8'($urandom), 0);
    do_reset();
    idle(6, 1);
    idle(12, 0);
    send(8'h55, 0);
    idle(14, 0);
    send(8'h56, 0);
    idle(4, 0);
    send(8'h57, 0);
    idle(20, 0);
    idle(6, 1);
    for (int i = 0; i < 400; i++) drive(($urandom % 3) != 0, 8'($urandom), ($urandom % 4) != 0, acc);
    idle(20, 1);
    check("drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
